// File: rtl/enable_arb_pkg.sv
// enable_arb_pkg: shared state, channel encoding and channel count for enable_arbiter.
package enable_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  typedef enum logic [1:0] {CH_A = 2'd0, CH_B = 2'd1, CH_C = 2'd2} ch_e;
  localparam int NUM_CH = 3;
endpackage

// File: rtl/enable_arbiter_prio_pick.sv
// prio_pick: fixed-priority (bit0 highest) one-hot pick over unmasked requests.
module prio_pick
  import enable_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] pick,
  output logic              any
);
  logic [NUM_CH-1:0] r;
  always_comb begin
    r    = req & ~mask;
    pick = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    any  = |r;
  end
endmodule

// File: rtl/enable_arbiter.sv
// enable_arbiter: three-channel fixed-priority one-hot enable generator with hold-limit
// fairness and a registered data output from the granted channel.
module enable_arbiter
  import enable_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             en_a,
  output logic             en_b,
  output logic             en_c,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_e            state, state_n;
  logic [NUM_CH-1:0] grant, grant_n, mask, pick;
  logic [HW-1:0]     hold_cnt, cnt_n;
  logic [WIDTH-1:0]  y_n;
  logic              any, held, expire;
  prio_pick u_pick (.req(req), .mask(mask), .pick(pick), .any(any));
  // Only an expiring grant masks itself, so a dropped grant re-arbitrates over everyone else.
  always_comb begin
    held    = |(req & grant);
    expire  = state == GRANT && held && hold_cnt == HW'(MAX_HOLD);
    mask    = expire ? grant : '0;
    state_n = state;
    grant_n = grant;
    cnt_n   = hold_cnt;
    if (state == IDLE || !held) begin
      state_n = any ? GRANT : IDLE;
      grant_n = pick;
      cnt_n   = any ? HW'(1) : '0;
    end else if (!expire) begin
      cnt_n = hold_cnt + HW'(1);
    end else begin
      grant_n = any ? pick : grant;
      cnt_n   = HW'(1);
    end
    y_n = grant_n[0] ? a : grant_n[1] ? b : grant_n[2] ? c : y;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      hold_cnt <= '0;
      y        <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      hold_cnt <= cnt_n;
      y        <= y_n;
      busy     <= |grant_n;
    end
  end
  assign {en_c, en_b, en_a} = grant;
  assign y_valid = busy;
  a_onehot: assert property (@(posedge clk) $onehot0({en_c, en_b, en_a}));
endmodule
